// File: rtl/mem_responder.sv
// Multi-cycle memory responder answering mem_en/rw requests with mfc.
// Define MEM_BOUNDS_CHK_EN to flag addresses >= DEPTH on err instead of wrapping.
module mem_responder #(
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        mfc,
    output logic        err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXL = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          rw_q, rw_d;
    logic          mfc_q, mfc_d;
    logic [15:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic          we;
    logic          oob;
    logic [AW-1:0] idx;

    logic [15:0] mem [DEPTH];

    assign idx = addr_q[AW-1:0];

`ifdef MEM_BOUNDS_CHK_EN
    assign oob = {16'd0, addr_q} >= 32'(DEPTH);
    assign err = err_q;
`else
    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^{addr_q, err_q};
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    assign mfc      = mfc_q;
    assign data_out = dout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_en) state_d = BUSY;
            BUSY: begin
                if (!mem_en)            state_d = IDLE;
                else if (cnt_q == '0)   state_d = DONE;
            end
            DONE: if (!mem_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        rw_d   = rw_q;
        mfc_d  = mfc_q;
        dout_d = dout_q;
        err_d  = err_q;
        we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    addr_d = addr;
                    data_d = data_in;
                    rw_d   = rw;
                    cnt_d  = rw ? CW'(READ_LAT - 1) : CW'(WRITE_LAT - 1);
                end
            end
            BUSY: begin
                if (mem_en && cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (mem_en) begin
                    mfc_d = 1'b1;
                    err_d = oob;
                    if (rw_q)      dout_d = oob ? 16'hDEAD : mem[idx];
                    else if (!oob) we = 1'b1;
                end
            end
            DONE: begin
                if (!mem_en) begin
                    mfc_d = 1'b0;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
            mfc_q  <= 1'b0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            rw_q   <= rw_d;
            mfc_q  <= mfc_d;
            dout_q <= dout_d;
            err_q  <= err_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= data_q;
    end

endmodule
